// File: rtl/alu_pkg.sv
// Shared types and helpers for the slice-serial ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        ADC = 4'd0,
        SBC = 4'd1,
        AND = 4'd2,
        EOR = 4'd3,
        ORA = 4'd4,
        LSR = 4'd5,
        ROR = 4'd6,
        ASL = 4'd7,
        ROL = 4'd8
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // Right shifts walk the operand from the MSB slice downwards.
    function automatic logic is_right_shift(input logic [3:0] op);
        logic r;
        case (op)
            LSR, ROR: r = 1'b1;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

    // Ops whose first slice consumes CARRY_IN; all others start from 0.
    function automatic logic seeds_carry(input logic [3:0] op);
        logic r;
        case (op)
            ADC, SBC, ROR, ROL: r = 1'b1;
            default:            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_slice.sv
// One SLICE-bit slice of the ALU. bit_in/bit_out carry the ripple bit
// (carry for arithmetic, shifted-out bit for shifts) between slices.
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [3:0]       op,
    input  logic             bit_in,
    output logic [SLICE-1:0] result,
    output logic             bit_out,
    output logic             ovf
);

    logic [SLICE-1:0] b_eff_s;
    logic [SLICE:0]   sum_s;
    logic [SLICE-1:0] shr_s;
    logic [SLICE-1:0] shl_s;

    // Slice arithmetic, logic and shift results selected by op.
    always_comb begin
        b_eff_s = (op == SBC) ? ~b : b;
        sum_s   = {1'b0, a} + {1'b0, b_eff_s} + {{SLICE{1'b0}}, bit_in};
        shr_s   = a >> 1'b1;
        shr_s[SLICE-1] = bit_in;
        shl_s   = a << 1'b1;
        shl_s[0] = bit_in;

        result  = {SLICE{1'b0}};
        bit_out = 1'b0;
        ovf     = 1'b0;
        case (op)
            ADC, SBC: begin
                result  = sum_s[SLICE-1:0];
                bit_out = sum_s[SLICE];
                ovf     = (a[SLICE-1] == b_eff_s[SLICE-1]) &&
                          (sum_s[SLICE-1] != a[SLICE-1]);
            end
            AND: result = a & b;
            EOR: result = a ^ b;
            ORA: result = a | b;
            LSR, ROR: begin
                result  = shr_s;
                bit_out = a[0];
            end
            ASL, ROL: begin
                result  = shl_s;
                bit_out = a[SLICE-1];
            end
            default: begin
                result  = {SLICE{1'b0}};
                bit_out = 1'b0;
                ovf     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_alu.sv
// Slice-serial ALU: processes WIDTH-bit operands SLICE bits per clock,
// with a start/busy/done handshake and results held until the next op.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CARRY_IN,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] OUT,
    output logic             CARRY,
    output logic             OVERFLOW,
    output logic             ZERO,
    output logic             NEGATIVE
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    alu_state_t       state_r;
    alu_state_t       state_next_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic [3:0]       op_r;
    logic             bit_r;
    logic             zero_acc_r;
    logic [CNT_W-1:0] cnt_r;

    logic             right_s;
    logic             last_s;
    logic [SLICE-1:0] a_slice_s;
    logic [SLICE-1:0] b_slice_s;
    logic [SLICE-1:0] res_s;
    logic             bit_out_s;
    logic             ovf_s;
    logic [WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0] a_next_s;
    logic [WIDTH-1:0] b_next_s;

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a       (a_slice_s),
        .b       (b_slice_s),
        .op      (op_r),
        .bit_in  (bit_r),
        .result  (res_s),
        .bit_out (bit_out_s),
        .ovf     (ovf_s)
    );

    // Pick the active slice and the shifted operand/result registers.
    always_comb begin
        right_s = is_right_shift(op_r);
        last_s  = (cnt_r == LAST_CNT);
        if (right_s) begin
            a_slice_s  = a_r[WIDTH-1 -: SLICE];
            b_slice_s  = b_r[WIDTH-1 -: SLICE];
            a_next_s   = a_r << SLICE;
            b_next_s   = b_r << SLICE;
            acc_next_s = (acc_r << SLICE) | WIDTH'(res_s);
        end else begin
            a_slice_s  = a_r[SLICE-1:0];
            b_slice_s  = b_r[SLICE-1:0];
            a_next_s   = a_r >> SLICE;
            b_next_s   = b_r >> SLICE;
            acc_next_s = (acc_r >> SLICE) | (WIDTH'(res_s) << (WIDTH - SLICE));
        end
    end

    // Next-state logic for the IDLE/RUN/DONE handshake.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand latch, per-slice accumulation and final result/flag update.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            acc_r      <= {WIDTH{1'b0}};
            op_r       <= 4'd0;
            bit_r      <= 1'b0;
            zero_acc_r <= 1'b1;
            cnt_r      <= {CNT_W{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            OUT        <= {WIDTH{1'b0}};
            CARRY      <= 1'b0;
            OVERFLOW   <= 1'b0;
            ZERO       <= 1'b0;
            NEGATIVE   <= 1'b0;
        end else begin
            busy <= (state_next_s == RUN);
            done <= (state_next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r        <= A;
                        b_r        <= B;
                        op_r       <= op;
                        bit_r      <= seeds_carry(op) ? CARRY_IN : 1'b0;
                        acc_r      <= {WIDTH{1'b0}};
                        zero_acc_r <= 1'b1;
                        cnt_r      <= {CNT_W{1'b0}};
                    end
                end
                RUN: begin
                    a_r        <= a_next_s;
                    b_r        <= b_next_s;
                    acc_r      <= acc_next_s;
                    bit_r      <= bit_out_s;
                    zero_acc_r <= zero_acc_r & (res_s == {SLICE{1'b0}});
                    cnt_r      <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        OUT      <= acc_next_s;
                        CARRY    <= bit_out_s;
                        OVERFLOW <= ovf_s;
                        ZERO     <= zero_acc_r & (res_s == {SLICE{1'b0}});
                        NEGATIVE <= acc_next_s[WIDTH-1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench: a 2-slice (SLICE=8) and a 4-slice (SLICE=4) instance
// share stimulus; results, flags and handshake timing are checked.
module tb_multicycle_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [15:0] A = 16'd0;
    logic [15:0] B = 16'd0;
    logic        CARRY_IN = 1'b0;

    logic        busy8, done8, carry8, ovf8, zero8, neg8;
    logic [15:0] out8;
    logic        busy4, done4, carry4, ovf4, zero4, neg4;
    logic [15:0] out4;

    int errors = 0;
    int checks = 0;
    int lat8, lat4, bcnt4;
    logic b8 [1:6];
    logic d8 [1:6];
    logic d4 [1:6];
    logic [15:0] o8 [1:6];
    logic [15:0] o4 [1:6];
    logic saw_done;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(16), .SLICE(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .CARRY_IN(CARRY_IN), .busy(busy8), .done(done8), .OUT(out8),
        .CARRY(carry8), .OVERFLOW(ovf8), .ZERO(zero8), .NEGATIVE(neg8)
    );

    multicycle_alu #(.WIDTH(16), .SLICE(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .CARRY_IN(CARRY_IN), .busy(busy4), .done(done4), .OUT(out4),
        .CARRY(carry4), .OVERFLOW(ovf4), .ZERO(zero4), .NEGATIVE(neg4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare results and flags of both instances against one expectation.
    task automatic check_res(input string tag, input logic [15:0] e_out, input logic e_c,
                             input logic e_v, input logic e_z, input logic e_n);
        check({tag, " out8"}, {16'd0, out8}, {16'd0, e_out});
        check({tag, " c8"}, {31'd0, carry8}, {31'd0, e_c});
        check({tag, " v8"}, {31'd0, ovf8}, {31'd0, e_v});
        check({tag, " z8"}, {31'd0, zero8}, {31'd0, e_z});
        check({tag, " n8"}, {31'd0, neg8}, {31'd0, e_n});
        check({tag, " out4"}, {16'd0, out4}, {16'd0, e_out});
        check({tag, " c4"}, {31'd0, carry4}, {31'd0, e_c});
        check({tag, " v4"}, {31'd0, ovf4}, {31'd0, e_v});
        check({tag, " z4"}, {31'd0, zero4}, {31'd0, e_z});
        check({tag, " n4"}, {31'd0, neg4}, {31'd0, e_n});
    endtask

    // Issue one op, scramble inputs after the start edge, and time both dones.
    task automatic run_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic c);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b; CARRY_IN = c;
        @(negedge clk);
        start = 1'b0; A = ~a; B = ~b; CARRY_IN = ~c; op = 4'd0;
        lat8 = -1; lat4 = -1; bcnt4 = 0;
        for (int n = 0; n < 12; n++) begin
            if (done8 && lat8 < 0) lat8 = n;
            if (done4 && lat4 < 0) lat4 = n;
            if (busy4 && lat4 < 0) bcnt4++;
            if (lat8 >= 0 && lat4 >= 0) break;
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst busy", {30'd0, busy8, busy4}, 32'd0);
        check("rst done", {30'd0, done8, done4}, 32'd0);
        check_res("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // ADC signed overflow into the MSB, plus handshake timing
        run_op(ADC, 16'h7FFF, 16'h0001, 1'b0);
        check("adc lat8", lat8, 32'd2);
        check("adc lat4", lat4, 32'd4);
        check("adc busy4 cycles", bcnt4, 32'd4);
        check_res("adc1", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);

        run_op(SBC, 16'h0000, 16'h0001, 1'b1);
        check_res("sbc1", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);

        run_op(SBC, 16'h8000, 16'h0001, 1'b1);
        check_res("sbc2", 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

        run_op(ROR, 16'h0001, 16'h0000, 1'b1);
        check_res("ror", 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);

        run_op(LSR, 16'h0001, 16'h0000, 1'b1);
        check_res("lsr", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

        run_op(ASL, 16'h8000, 16'h0000, 1'b1);
        check_res("asl", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

        run_op(ROL, 16'h4000, 16'h0000, 1'b1);
        check_res("rol", 16'h8001, 1'b0, 1'b0, 1'b0, 1'b1);

        run_op(ADC, 16'hFFFF, 16'h0001, 1'b0);
        check_res("adc wrap", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

        run_op(AND, 16'hF0F0, 16'hFF00, 1'b1);
        check_res("and", 16'hF000, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(EOR, 16'hF0F0, 16'hFF00, 1'b1);
        check_res("eor", 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(ORA, 16'hF0F0, 16'hFF00, 1'b1);
        check_res("ora", 16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b1);

        run_op(4'hF, 16'hFFFF, 16'hFFFF, 1'b1);
        check("undef lat8", lat8, 32'd2);
        check_res("undef", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

        // start held high: accepts only on edges k and k+N+2
        @(negedge clk);
        start = 1'b1; op = ADC; A = 16'h0001; B = 16'h0001; CARRY_IN = 1'b0;
        @(negedge clk);
        A = 16'h0002; B = 16'h0002;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            b8[i] = busy8; d8[i] = done8; o8[i] = out8;
            d4[i] = done4; o4[i] = out4;
        end
        start = 1'b0;
        check("hold b8[1]", {31'd0, b8[1]}, 32'd1);
        check("hold d8[2]", {31'd0, d8[2]}, 32'd1);
        check("hold o8[2]", {16'd0, o8[2]}, 32'h0002);
        check("hold b8[3]", {30'd0, b8[3], d8[3]}, 32'd0);
        check("hold b8[4]", {31'd0, b8[4]}, 32'd1);
        check("hold d8[6]", {31'd0, d8[6]}, 32'd1);
        check("hold o8[6]", {16'd0, o8[6]}, 32'h0004);
        check("hold d4[4]", {31'd0, d4[4]}, 32'd1);
        check("hold o4[4]", {16'd0, o4[4]}, 32'h0002);
        check("hold d4[5]", {31'd0, d4[5]}, 32'd0);
        repeat (8) @(negedge clk);

        // Reset mid-RUN discards the operation
        run_op(ADC, 16'h7FFF, 16'h0001, 1'b0);
        @(negedge clk);
        start = 1'b1; op = ADC; A = 16'h1234; B = 16'h1111; CARRY_IN = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", {30'd0, busy8, busy4}, 32'd0);
        check("midrst done", {30'd0, done8, done4}, 32'd0);
        check_res("midrst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done8 || done4 || busy8 || busy4) saw_done = 1'b1;
        end
        check("midrst no activity", {31'd0, saw_done}, 32'd0);

        run_op(ADC, 16'h0001, 16'h0001, 1'b0);
        check("post lat8", lat8, 32'd2);
        check("post lat4", lat4, 32'd4);
        check_res("post", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised, sequential successor to the 8-bit RP2A03 ALU.
- Operates on WIDTH-bit operands by processing one SLICE-bit slice per clock, rippling carry and shift bits through a register between slices.
- Adds a start/busy/done handshake, subtract and rotate/left-shift ops, and ZERO/NEGATIVE flags.
- Sits beside the CPU datapath for 16-bit address arithmetic and for future wide-math helpers.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle. SLICE == WIDTH gives single-slice operation.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only in IDLE
- op  input  4  operation code (alu_op_t)
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- CARRY_IN  input  1  carry / rotate-in bit
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results become valid
- OUT  output  WIDTH  result
- CARRY  output  1  carry out
- OVERFLOW  output  1  signed overflow (ADC/SBC only)
- ZERO  output  1  OUT == 0
- NEGATIVE  output  1  OUT[WIDTH-1]

Behaviour:
- Clock/reset (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: state IDLE; busy, done, OUT, CARRY, OVERFLOW, ZERO, NEGATIVE all 0. Reset has priority in every state, including mid-RUN: the partial result is discarded and the outputs are zeroed.
- N = WIDTH/SLICE.
- States:
  - IDLE: on start=1, latch A, B, op, CARRY_IN; go to RUN; busy=1.
  - RUN: one slice per clock edge for N edges, then go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle; results valid; next state IDLE.
- Latency:
  - start sampled on edge k, so the slices compute on edges k+1..k+N.
  - done is high in the cycle after edge k+N.
  - The DONE state itself accepts no start. The earliest new start is sampled on edge k+N+2.
- start is ignored while busy or in DONE. Inputs may change after the start edge without affecting the operation.
- Output holding: OUT and flags update only on the final slice edge and hold until the next completion or reset. Intermediate slices accumulate in internal registers.
- Operations (alu_op_t):
  - ADC = A+B+CARRY_IN. SBC = A+~B+CARRY_IN (6502 borrow convention).
  - AND, EOR, ORA.
  - LSR: 0 in at MSB, carry = A[0].
  - ROR: CARRY_IN in at MSB, carry = A[0].
  - ASL: 0 in at LSB, carry = A[WIDTH-1].
  - ROL: CARRY_IN in at LSB, carry = A[WIDTH-1].
- Slice order:
  - ADC, SBC, AND, EOR, ORA, ASL, ROL: LSB slice first.
  - LSR, ROR: MSB slice first.
  - The inter-slice bit register is seeded with CARRY_IN for ADC/SBC/ROR/ROL and with 0 for LSR/ASL.
- Flags:
  - CARRY: final ripple bit for ADC/SBC/shifts; 0 for logic ops.
  - OVERFLOW: computed from the MSB slice, (A[W-1]==B'[W-1]) && (OUT[W-1]!=A[W-1]), where B' = ~B for SBC; 0 for all other ops.
  - ZERO: AND-accumulated across slices. NEGATIVE: OUT[WIDTH-1].
- Undefined op codes: complete normally in N cycles with OUT=0, CARRY=0, OVERFLOW=0, ZERO=1, NEGATIVE=0.
- Wrap-around: arithmetic is modulo 2^WIDTH, and the carry reflects bit WIDTH.

Decomposition:
- Package alu_pkg:
  - alu_op_t enum (4 bits): ADC=0, SBC=1, AND=2, EOR=3, ORA=4, LSR=5, ROR=6, ASL=7, ROL=8.
  - alu_state_t enum: IDLE, RUN, DONE.
  - Helper function is_right_shift(op).
- One combinational sub-module, alu_slice (SLICE-bit):
  - Inputs: a, b, op, bit_in.
  - Outputs: result, bit_out, ovf.
- multicycle_alu holds the FSM, the slice counter, operand/result shift registers and the flag accumulation.

Test Plan:
- WIDTH=16/SLICE=8, ADC A=0x7FFF B=0x0001 CIN=0 -> OUT=0x8000, C=0, V=1, N=1, Z=0; done one cycle after the 2nd slice edge (2 slice edges after the start edge).
- SBC A=0x0000 B=0x0001 CIN=1 -> OUT=0xFFFF, C=0, V=0, N=1, Z=0.
- ROR A=0x0001 CIN=1 -> OUT=0x8000, C=1, N=1; LSR same operands -> OUT=0x0000, C=1, Z=1.
- ASL A=0x8000 -> OUT=0x0000, C=1, Z=1; ROL A=0x4000 CIN=1 -> OUT=0x8001, C=0, N=1.
- WIDTH=16/SLICE=4, ADC A=0xFFFF B=0x0001 CIN=0 -> OUT=0x0000, C=1, V=0, Z=1; slices on 4 edges; busy high through the RUN cycles.
- start held high continuously with new operands -> no accept while busy or in DONE, next accept on edge k+N+2. rst pulsed mid-RUN -> all outputs 0, no done pulse; a following ADC 0x0001+0x0001 completes with OUT=0x0002.
